// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiply datapath: operand
// classes, flag bit positions and format-derived constants.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  localparam int FLAG_W         = 5;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_SPECIAL   = 0;

  // Widest format the constant helpers can describe; callers slice down.
  localparam int FP_MAX_W = 128;

  function automatic int fp_bias(input int exp_len);
    return (1 << (exp_len - 1)) - 1;
  endfunction

  // Positive infinity: all-ones exponent, zero fraction, sign clear.
  function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_len, input int frac_len);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_len; i++) v[frac_len + i] = 1'b1;
    return v;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the quiet bit set.
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_len, input int frac_len);
    logic [FP_MAX_W-1:0] v;
    v = fp_inf(exp_len, frac_len);
    v[frac_len - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign/exponent/significand and classifies it.
// Subnormals are treated as zero, so their significand is forced to 0.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_LEN       = 11,
  parameter int FRAC_LEN      = 52,
  parameter int PRECISION_LEN = 1 + EXP_LEN + FRAC_LEN
) (
  input  logic [PRECISION_LEN-1:0] operand,
  output logic                     sign,
  output logic [EXP_LEN-1:0]       exponent,
  output logic [FRAC_LEN:0]        significand,
  output fp_class_e                cls
);

  logic [FRAC_LEN-1:0] frac;

  assign sign     = operand[PRECISION_LEN-1];
  assign exponent = operand[PRECISION_LEN-2:FRAC_LEN];
  assign frac     = operand[FRAC_LEN-1:0];

  // Classify; hidden bit is only attached for normal operands.
  always_comb begin
    significand = '0;
    cls         = CLS_NORM;
    if (exponent == '1) begin
      if (frac == '0)              cls = CLS_INF;
      else if (frac[FRAC_LEN-1])   cls = CLS_QNAN;
      else                         cls = CLS_SNAN;
    end else if (exponent == '0) begin
      cls = CLS_ZERO;
    end else begin
      significand = {1'b1, frac};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control, a pass-through tag and a per-result flag vector.
// Stage 1 unpacks/classifies, stage 2 multiplies significands and resolves
// special operands, stage 3 normalises, rounds (nearest-even) and packs.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_LEN       = 11,
  parameter int FRAC_LEN      = 52,
  parameter int PRECISION_LEN = 1 + EXP_LEN + FRAC_LEN,
  parameter int TAG_LEN       = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PRECISION_LEN-1:0] a_operand,
  input  logic [PRECISION_LEN-1:0] b_operand,
  input  logic [TAG_LEN-1:0]       in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PRECISION_LEN-1:0] result,
  output logic [TAG_LEN-1:0]       out_tag,
  output logic [FLAG_W-1:0]        flags
);

  localparam int EW     = EXP_LEN + 2;
  localparam int SIG_W  = FRAC_LEN + 1;
  localparam int PROD_W = 2 * SIG_W;

  localparam int                         BIAS_I   = fp_bias(EXP_LEN);
  localparam logic [EW-1:0]              BIAS     = BIAS_I[EW-1:0];
  localparam logic [EW-1:0]              EXP_MAX  = {2'b00, {EXP_LEN{1'b1}}};
  localparam logic [FP_MAX_W-1:0]        INF_W    = fp_inf(EXP_LEN, FRAC_LEN);
  localparam logic [FP_MAX_W-1:0]        QNAN_W   = fp_qnan(EXP_LEN, FRAC_LEN);
  localparam logic [PRECISION_LEN-2:0]   INF_MAG  = INF_W[PRECISION_LEN-2:0];
  localparam logic [PRECISION_LEN-1:0]   QNAN_VAL = QNAN_W[PRECISION_LEN-1:0];

  logic stall;
  logic accept;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  logic               a_sign, b_sign;
  logic [EXP_LEN-1:0] a_exp, b_exp;
  logic [FRAC_LEN:0]  a_sig, b_sig;
  fp_class_e          a_cls, b_cls;

  fp_unpack #(.EXP_LEN(EXP_LEN), .FRAC_LEN(FRAC_LEN)) u_unpack_a (
    .operand(a_operand), .sign(a_sign), .exponent(a_exp), .significand(a_sig), .cls(a_cls)
  );

  fp_unpack #(.EXP_LEN(EXP_LEN), .FRAC_LEN(FRAC_LEN)) u_unpack_b (
    .operand(b_operand), .sign(b_sign), .exponent(b_exp), .significand(b_sig), .cls(b_cls)
  );

  logic               s1_valid;
  logic [TAG_LEN-1:0] s1_tag;
  logic               s1_sign;
  fp_class_e          s1_cls_a, s1_cls_b;
  logic [EW-1:0]      s1_exp;
  logic [FRAC_LEN:0]  s1_sig_a, s1_sig_b;

  // Stage 1: capture classified operands and the biased exponent sum.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_sign  <= 1'b0;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
      s1_exp   <= '0;
      s1_sig_a <= '0;
      s1_sig_b <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_tag   <= in_tag;
      s1_sign  <= a_sign ^ b_sign;
      s1_cls_a <= a_cls;
      s1_cls_b <= b_cls;
      s1_exp   <= {2'b00, a_exp} + {2'b00, b_exp} - BIAS;
      s1_sig_a <= a_sig;
      s1_sig_b <= b_sig;
    end
  end

  logic                     a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, inf_x_zero;
  logic                     spec_hit, spec_inv;
  logic [PRECISION_LEN-1:0] spec_res;

  assign a_snan     = (s1_cls_a == CLS_SNAN);
  assign b_snan     = (s1_cls_b == CLS_SNAN);
  assign a_nan      = a_snan || (s1_cls_a == CLS_QNAN);
  assign b_nan      = b_snan || (s1_cls_b == CLS_QNAN);
  assign a_inf      = (s1_cls_a == CLS_INF);
  assign b_inf      = (s1_cls_b == CLS_INF);
  assign a_zero     = (s1_cls_a == CLS_ZERO);
  assign b_zero     = (s1_cls_b == CLS_ZERO);
  assign inf_x_zero = (a_inf && b_zero) || (a_zero && b_inf);

  // Special operands resolve in priority order: NaN, Inf, zero.
  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (a_nan || b_nan || inf_x_zero) begin
      spec_res = QNAN_VAL;
      spec_inv = a_snan || b_snan || inf_x_zero;
    end else if (a_inf || b_inf) begin
      spec_res = {s1_sign, INF_MAG};
    end else if (a_zero || b_zero) begin
      spec_res = {s1_sign, {(PRECISION_LEN-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic                     s2_valid;
  logic [TAG_LEN-1:0]       s2_tag;
  logic                     s2_sign;
  logic                     s2_spec, s2_spec_inv;
  logic [PRECISION_LEN-1:0] s2_spec_res;
  logic [EW-1:0]            s2_exp;
  logic [PROD_W-1:0]        s2_prod;

  // Stage 2: full-width significand product and resolved special case.
  always_ff @(posedge clk) begin
    if (srst) begin
      s2_valid    <= 1'b0;
      s2_tag      <= '0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_inv <= 1'b0;
      s2_spec_res <= '0;
      s2_exp      <= '0;
      s2_prod     <= '0;
    end else if (!stall) begin
      s2_valid    <= s1_valid;
      s2_tag      <= s1_tag;
      s2_sign     <= s1_sign;
      s2_spec     <= spec_hit;
      s2_spec_inv <= spec_inv;
      s2_spec_res <= spec_res;
      s2_exp      <= s1_exp;
      s2_prod     <= {{SIG_W{1'b0}}, s1_sig_a} * {{SIG_W{1'b0}}, s1_sig_b};
    end
  end

  logic                     prod_msb, guard, sticky, round_up, carry, ovf, unf;
  logic [PROD_W-2:0]        prod_norm;
  logic [FRAC_LEN-1:0]      mant, mant_rnd;
  logic [EW-1:0]            exp_fin;
  logic [PRECISION_LEN-1:0] res_nxt;
  logic [FLAG_W-1:0]        flags_nxt;

  // Product lies in [1,4); align so the leading one sits just above the kept fraction.
  assign prod_msb  = s2_prod[PROD_W-1];
  assign prod_norm = prod_msb ? s2_prod[PROD_W-2:0] : {s2_prod[PROD_W-3:0], 1'b0};
  assign mant      = prod_norm[PROD_W-2 -: FRAC_LEN];
  assign guard     = prod_norm[FRAC_LEN];
  assign sticky    = |prod_norm[FRAC_LEN-1:0];
  assign round_up  = guard && (sticky || mant[0]);
  assign {carry, mant_rnd} = {1'b0, mant} + {{FRAC_LEN{1'b0}}, round_up};
  // A rounding carry leaves mant_rnd at zero, i.e. significand 1.0 one binade up.
  assign exp_fin   = s2_exp + {{(EW-1){1'b0}}, prod_msb} + {{(EW-1){1'b0}}, carry};
  assign ovf       = !exp_fin[EW-1] && (exp_fin >= EXP_MAX);
  assign unf       = exp_fin[EW-1] || (exp_fin == '0);

  // Pick between special, overflow, flush-to-zero and the normally packed result.
  always_comb begin
    res_nxt                 = {s2_sign, exp_fin[EXP_LEN-1:0], mant_rnd};
    flags_nxt               = '0;
    flags_nxt[FLAG_INEXACT] = guard || sticky;
    if (s2_spec) begin
      res_nxt                 = s2_spec_res;
      flags_nxt               = '0;
      flags_nxt[FLAG_SPECIAL] = 1'b1;
      flags_nxt[FLAG_INVALID] = s2_spec_inv;
    end else if (ovf) begin
      res_nxt                  = {s2_sign, INF_MAG};
      flags_nxt                = '0;
      flags_nxt[FLAG_OVERFLOW] = 1'b1;
      flags_nxt[FLAG_INEXACT]  = 1'b1;
    end else if (unf) begin
      res_nxt                   = {s2_sign, {(PRECISION_LEN-1){1'b0}}};
      flags_nxt                 = '0;
      flags_nxt[FLAG_UNDERFLOW] = 1'b1;
      flags_nxt[FLAG_INEXACT]   = 1'b1;
    end
  end

  // Stage 3: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      result    <= res_nxt;
      out_tag   <= s2_tag;
      flags     <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (double precision). Expected results come
// from a reference built on native real arithmetic plus the flush rules.
module tb_fp_mul_pipe;

  localparam logic [4:0] F_INV = 5'b10000;
  localparam logic [4:0] F_OVF = 5'b01000;
  localparam logic [4:0] F_UNF = 5'b00100;
  localparam logic [4:0] F_INX = 5'b00010;
  localparam logic [4:0] F_SPC = 5'b00001;

  logic        clk = 1'b0;
  logic        srst, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a_operand, b_operand, result;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  flags;

  fp_mul_pipe dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   n_pushed = 0, n_popped = 0, n_discarded = 0;
  bit   rand_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: IEEE double product with DAZ inputs and FTZ results.
  function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [4:0] f);
    logic [10:0]  ea, eb;
    logic [51:0]  fa, fb;
    bit           a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, ixz;
    logic         s;
    logic [63:0]  pb;
    logic [105:0] p;
    int           hi, lo;
    ea = a[62:52]; eb = b[62:52]; fa = a[51:0]; fb = b[51:0];
    a_nan  = (ea == 11'h7FF) && (fa != 0);
    b_nan  = (eb == 11'h7FF) && (fb != 0);
    a_snan = a_nan && !fa[51];
    b_snan = b_nan && !fb[51];
    a_inf  = (ea == 11'h7FF) && (fa == 0);
    b_inf  = (eb == 11'h7FF) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    ixz    = (a_inf && b_zero) || (a_zero && b_inf);
    s      = a[63] ^ b[63];
    if (a_nan || b_nan || ixz) begin
      r = 64'h7FF8000000000000;
      f = F_SPC | ((a_snan || b_snan || ixz) ? F_INV : 5'b0);
    end else if (a_inf || b_inf) begin
      r = {s, 63'h7FF0000000000000};
      f = F_SPC;
    end else if (a_zero || b_zero) begin
      r = {s, 63'b0};
      f = F_SPC;
    end else begin
      pb = $realtobits($bitstoreal(a) * $bitstoreal(b));
      if (pb[62:52] == 11'h7FF) begin
        r = {s, 63'h7FF0000000000000};
        f = F_OVF | F_INX;
      end else if (pb[62:52] == 11'h000) begin
        r = {s, 63'b0};
        f = F_UNF | F_INX;
      end else begin
        r = pb;
        // Exact product needs more than 53 significant bits => rounded.
        p  = {53'b0, 1'b1, fa} * {53'b0, 1'b1, fb};
        hi = 0; lo = 0;
        for (int i = 0; i < 106; i++) if (p[i]) hi = i;
        for (int i = 105; i >= 0; i--) if (p[i]) lo = i;
        f = ((hi - lo + 1) > 53) ? F_INX : 5'b0;
      end
    end
  endfunction

  function automatic logic [63:0] gen_op();
    logic [63:0] v;
    int          sel;
    v   = {$urandom, $urandom};
    sel = $urandom_range(0, 19);
    case (sel)
      0:       v[62:52] = 11'h000;
      1:       begin v[62:52] = 11'h7FF; if ($urandom_range(0, 1) == 0) v[51:0] = '0; end
      2:       v[62:52] = 11'($urandom_range(1990, 2046));
      3:       v[62:52] = 11'($urandom_range(1, 60));
      4:       begin v[62:52] = 11'($urandom_range(900, 1100)); v[51:0] = '0; end
      default: v[62:52] = 11'($urandom_range(700, 1350));
    endcase
    return v;
  endfunction

  // Drive one operation; expectation is queued at the cycle it is accepted.
  task automatic issue_exp(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                           input bit lat, input logic [63:0] r, input logic [4:0] f);
    exp_t e;
    int   tries;
    bit   ok;
    tries = 0; ok = 0;
    in_valid = 1'b1; a_operand = a; b_operand = b; in_tag = tag;
    forever begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      tries++;
      if (tries > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", tries);
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      e = '{res: r, flg: f, tag: tag, acc: cyc, lat: lat};
      sbq.push_back(e);
      n_pushed++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [3:0] tag);
    logic [63:0] a, b, r;
    logic [4:0]  f;
    a = gen_op();
    b = gen_op();
    ref_mul(a, b, r, f);
    issue_exp(a, b, tag, 1'b0, r, f);
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: handshake/stall rules and in-order scoreboard comparison.
  logic [63:0] held_res;
  logic [3:0]  held_tag;
  logic [4:0]  held_flg;
  bit          prev_stall = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (srst) begin
        prev_stall = 0;
      end else begin
        if (out_valid && !out_ready) begin
          check("in_ready_stalled", in_ready, 1'b0);
          if (prev_stall) begin
            check("stall_result", result, held_res);
            check("stall_tag", out_tag, held_tag);
            check("stall_flags", flags, held_flg);
          end
          prev_stall = 1;
          held_res = result; held_tag = out_tag; held_flg = flags;
        end else begin
          prev_stall = 0;
          check("in_ready_free", in_ready, 1'b1);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got result %h tag %h, expected no output", result, out_tag);
          end else begin
            e = sbq.pop_front();
            n_popped++;
            check("result", result, e.res);
            check("tag", out_tag, e.tag);
            check("flags", flags, e.flg);
            if (e.lat) check("latency", cyc - e.acc, 3);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    srst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_operand = '0; b_operand = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_result", result, 64'h0);
    check("reset_tag", out_tag, 4'h0);
    check("reset_flags", flags, 5'h0);
    @(posedge clk); #1;

    issue_exp(64'h3FF8000000000000, 64'h4000000000000000, 4'h1, 1'b1, 64'h4008000000000000, 5'b0);
    wait_drain(20);
    issue_exp(64'h3FF0000000000001, 64'h3FF8000000000000, 4'h2, 1'b1, 64'h3FF8000000000002, F_INX);
    wait_drain(20);
    issue_exp(64'h7FF0000000000000, 64'h0000000000000000, 4'h3, 1'b1, 64'h7FF8000000000000, F_INV | F_SPC);
    wait_drain(20);
    issue_exp(64'h7FE0000000000000, 64'h4000000000000000, 4'h4, 1'b1, 64'h7FF0000000000000, F_OVF | F_INX);
    wait_drain(20);
    issue_exp(64'h0010000000000000, 64'h3FE0000000000000, 4'h5, 1'b1, 64'h0000000000000000, F_UNF | F_INX);
    wait_drain(20);
    issue_exp(64'h0000000000000001, 64'h3FF0000000000000, 4'h6, 1'b1, 64'h0000000000000000, F_SPC);
    wait_drain(20);
    issue_exp(64'hFFF0000000000000, 64'h4000000000000000, 4'h7, 1'b0, 64'hFFF0000000000000, F_SPC);
    issue_exp(64'h7FF0000000000001, 64'h3FF0000000000000, 4'h8, 1'b0, 64'h7FF8000000000000, F_INV | F_SPC);
    issue_exp(64'hBFF0000000000000, 64'h0000000000000000, 4'h9, 1'b0, 64'h8000000000000000, F_SPC);
    wait_drain(20);

    // Backpressure: 8 back-to-back ops, consumer stalls then drains 1-of-2.
    base = n_popped;
    fork
      begin
        for (int i = 0; i < 8; i++) issue_rand(4'(i));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = (k < 4) ? 1'b1 : (k < 10) ? 1'b0 : ((k % 2) == 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(50);
    check("backpressure_count", n_popped - base, 8);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    issue_rand(4'hA);
    issue_rand(4'hB);
    issue_rand(4'hC);
    srst = 1'b1;
    n_discarded += sbq.size();
    sbq.delete();
    @(posedge clk); #1;
    srst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    issue_exp(64'h3FF8000000000000, 64'h4000000000000000, 4'hD, 1'b1, 64'h4008000000000000, 5'b0);
    wait_drain(20);

    // Randomised traffic with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) issue_rand(4'(i));
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(200);

    check("ops_completed", n_popped, n_pushed - n_discarded);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier. Successor to the single-cycle FP multiply unit in the datapath.
- Adds three things the earlier unit lacks:
  - valid/ready handshake with backpressure, plus a sideband tag;
  - round-to-nearest-even, with correct NaN/Inf/zero handling;
  - a sticky-free per-result flag vector.
- Sits between the operand issue logic and the result writeback/accumulate stage.

Parameters:
- EXP_LEN, 11, exponent width
- FRAC_LEN, 52, stored fraction width
- PRECISION_LEN, 1+EXP_LEN+FRAC_LEN, operand/result width (derived; do not override)
- TAG_LEN, 4, sideband tag width, carried unchanged alongside each operation

Ports:
- clk  in  1  clock, rising edge
- srst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit accepts the pair this cycle
- a_operand  in  PRECISION_LEN  operand A
- b_operand  in  PRECISION_LEN  operand B
- in_tag  in  TAG_LEN  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  PRECISION_LEN  product
- out_tag  out  TAG_LEN  tag of this result
- flags  out  5  {invalid, overflow, underflow, inexact, special}, qualified by out_valid

Behaviour:
- Reset: synchronous on srst=1. All stage valid bits, out_valid, result, out_tag and flags clear to 0. Any in-flight operations are discarded. in_ready=1 in the cycle after reset.
- Pipeline: 3 stages, latency 3 cycles from accepted input (in_valid&&in_ready) to out_valid, with no stall.
- Handshake and stalls:
  - stall = out_valid && !out_ready. Stall freezes all stages.
  - in_ready = !stall, combinational.
  - Bubbles do not collapse: a stalled pipeline holds its contents exactly.
  - Result, out_tag and flags are stable while out_valid=1 and out_ready=0.
  - Throughput is 1 operation/cycle when out_ready is held high.
- S1 (unpack/classify):
  - Extract sign = sa^sb, exponents and fractions.
  - Classify each operand as zero, subnormal, normal, Inf or NaN.
  - Subnormal inputs are flushed to signed zero (DAZ).
  - Compute biased exponent sum ea+eb-bias in EXP_LEN+2-bit signed arithmetic, where bias=2^(EXP_LEN-1)-1.
- S2 (multiply): (FRAC_LEN+1)x(FRAC_LEN+1) unsigned significand product, 2*(FRAC_LEN+1) bits.
- S3 (normalise/round/pack):
  - If the product MSB is set, shift right by 1 and increment the exponent.
  - Guard = first dropped bit. Sticky = OR of the remaining dropped bits.
  - Round-to-nearest-even: increment when guard && (sticky || lsb).
  - A rounding carry-out renormalises: exponent +1, significand = 1.0.
- Special-case priority, highest first (special=1 for rows 1-3):
  1. Either operand NaN, or Inf×0: canonical quiet NaN {0, all-ones exp, 1, zeros}. invalid=1 only for sNaN or Inf×0.
  2. Either operand Inf: signed Inf.
  3. Either operand zero (after DAZ): signed zero.
  4. Final biased exponent ≥ 2^EXP_LEN-1: signed Inf, overflow=1, inexact=1.
  5. Final biased exponent ≤ 0: signed zero (FTZ), underflow=1, inexact=1.
  6. Otherwise: normal pack. inexact = guard||sticky.
- Simultaneous input acceptance and output drain in one cycle is legal and required at full throughput.

Decomposition:
- Shared package fp_pkg holds:
  - the class encoding (ZERO, NORM, INF, QNAN, SNAN);
  - flag bit index constants;
  - functions for bias, canonical NaN and Inf constants, parametrised by EXP_LEN/FRAC_LEN.
- One natural sub-module, fp_unpack: classify plus DAZ for a single operand, instantiated twice in S1.
- Multiply and round stay inline.

Test Plan (all values default double):
- 0x3FF8000000000000 × 0x4000000000000000, out_ready=1 → result 0x4008000000000000, flags 0, out_valid exactly 3 cycles after accept.
- Tie case: 0x3FF0000000000001 × 0x3FF8000000000000 → 0x3FF8000000000002 (rounded to even), inexact=1.
- 0x7FF0000000000000 × 0x0000000000000000 → 0x7FF8000000000000, invalid=1, special=1. Also 0x7FE0000000000000 × 0x4000000000000000 → 0x7FF0000000000000, overflow=1, inexact=1.
- 0x0010000000000000 × 0x3FE0000000000000 → 0x0000000000000000, underflow=1. Also subnormal input 0x0000000000000001 × 0x3FF0000000000000 → +0, special=1.
- Backpressure:
  - Stimulus: 8 back-to-back ops with tags 0..7; out_ready held low for cycles 4-9, then pulsed 1-of-2.
  - Required: in_ready low during the stall, no op lost or duplicated, results and tags emerge in order.
  - Required: result, out_tag and flags stay stable while stalled.
- Reset mid-operation: srst=1 for 1 cycle with 3 ops in flight → out_valid=0 the next cycle, no stale result ever appears, and a new op issued afterwards completes with 3-cycle latency.
